// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set codes for the encoder and decoder: class codes, funct
// encodings, fixed words and the encoder FSM state type.
package instr_encoder_pkg;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ITYPE = 3'd1;
    localparam logic [2:0] OP_PTYPE = 3'd2;
    localparam logic [2:0] OP_MTYPE = 3'd3;
    localparam logic [2:0] OP_CTYPE = 3'd4;
    localparam logic [2:0] OP_FTYPE = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [3:0] MEM_LW = 4'b0000;
    localparam logic [3:0] MEM_SW = 4'b0001;
    localparam logic [3:0] MEM_LB = 4'b1000;
    localparam logic [3:0] MEM_SB = 4'b1001;

    localparam logic [2:0] CTL_JMP  = 3'b000;
    localparam logic [2:0] CTL_CALL = 3'b001;
    localparam logic [2:0] CTL_BR   = 3'b010;
    localparam logic [2:0] CTL_EXIT = 3'b111;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] EXIT_WORD = {OP_CTYPE, 16'h0000, CTL_EXIT, 10'h000};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_EXIT,
        ST_DONE
    } enc_state_t;

    function automatic logic is_mem_load(input logic [3:0] funct4);
        return (funct4 == MEM_LW) || (funct4 == MEM_LB);
    endfunction

    function automatic logic is_mem_store(input logic [3:0] funct4);
        return (funct4 == MEM_SW) || (funct4 == MEM_SB);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; the head is visible combinationally.
// A flush that coincides with a push keeps only the new entry.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;

    assign wr_idx = flush ? '0 : wr_ptr[PTR_W-1:0];
    assign head   = mem[rd_ptr[PTR_W-1:0]];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? (PTR_W + 1)'(1) : '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && (flush || !full)) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs request fields into instruction words, buffers them
// and streams them into instruction memory, closing each program with an EXIT word.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [3:0]            req_funct4,
    input  logic                  req_pred,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [13:0]           req_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    input  logic                  imem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    enc_state_t            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  error_q;
    logic                  done_q;
    logic                  ovf_q;

    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic                  accept;
    logic                  streaming;
    logic                  write_done;
    logic                  addr_max;
    logic                  ovf_event;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    always_comb begin
        enc_word        = NOP_WORD;
        enc_legal       = 1'b1;
        enc_word[31:29] = req_op;
        enc_word[28]    = req_pred;
        enc_word[13:10] = req_funct4;
        enc_word[9:5]   = req_rs1;
        enc_word[4:0]   = req_rd;
        case (req_op)
            OP_RTYPE, OP_FTYPE: begin
                enc_word[18:14] = req_rs2;
            end
            OP_ITYPE, OP_PTYPE: begin
                enc_word[27:14] = req_imm;
            end
            OP_MTYPE: begin
                if (is_mem_load(req_funct4)) begin
                    enc_word[27:14] = req_imm;
                end else if (is_mem_store(req_funct4)) begin
                    // Stores have no rd, so the low immediate bits take its slot.
                    enc_word[27:19] = req_imm[13:5];
                    enc_word[18:14] = req_rs2;
                    enc_word[4:0]   = req_imm[4:0];
                end else begin
                    enc_legal = 1'b0;
                end
            end
            OP_CTYPE: begin
                enc_word[27:14] = req_imm;
                enc_word[13]    = 1'b0;
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
        if (!enc_legal) enc_word = NOP_WORD;
    end

    assign streaming  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign req_ready  = (state_q == ST_RUN) && !fifo_full && !finish;
    assign accept     = req_valid && req_ready;
    assign imem_we    = (streaming && !fifo_empty) || ((state_q == ST_EXIT) && !ovf_q);
    assign imem_wdata = !imem_we ? '0 :
                        (state_q == ST_EXIT) ? DATA_WIDTH'(EXIT_WORD) : fifo_head;
    assign imem_addr  = addr_q;
    assign write_done = imem_we && imem_ready;
    assign addr_max   = (addr_q == {ADDR_WIDTH{1'b1}});
    assign ovf_event  = streaming && write_done && addr_max;

    assign fifo_push  = accept && enc_legal && (start || !ovf_event);
    assign fifo_pop   = streaming && write_done;
    assign fifo_flush = start || ovf_event;

    assign busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_EXIT);
    assign done  = done_q;
    assign error = error_q;

    instr_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (DATA_WIDTH'(enc_word)),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A write at the top address ends the program early: no wrap, no EXIT word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            error_q <= accept && !enc_legal;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept && !enc_legal) error_q <= 1'b1;
            case (state_q)
                ST_RUN, ST_DRAIN: begin
                    if (ovf_event) begin
                        error_q <= 1'b1;
                        ovf_q   <= 1'b1;
                        state_q <= ST_EXIT;
                    end else begin
                        if (write_done) addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (state_q == ST_RUN && finish)
                            state_q <= ST_DRAIN;
                        else if (state_q == ST_DRAIN && fifo_empty)
                            state_q <= ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    if (ovf_q || write_done) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, back-pressure, random
// traffic against a field-arithmetic model, address overflow and mid-run reset.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  op;
        logic        pred;
        logic [3:0]  funct4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [13:0] imm;
    } req_t;

    typedef struct {
        req_t        req;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] word;
    } wr_t;

    localparam logic [31:0] EXIT_WORD = 32'h8000_1C00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [3:0]  req_funct4 = '0;
    logic        req_pred = 1'b0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [13:0] req_imm = '0;
    logic        imem_ready = 1'b0;

    logic        rdy1, we1, busy1, done1, err1;
    logic [9:0]  addr1;
    logic [31:0] wdata1;
    logic        rdy2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];
    wr_t  mon_exp;
    int   next_addr = 0;
    bit   ill_seen = 1'b0;
    bit   sel_small = 1'b0;
    bit   rand_rdy = 1'b0;
    vec_t tbl[13];

    logic        t_ready, t_we, t_busy, t_done, t_error;
    logic [9:0]  t_addr;
    logic [31:0] t_wdata;

    assign t_ready = sel_small ? rdy2   : rdy1;
    assign t_we    = sel_small ? we2    : we1;
    assign t_busy  = sel_small ? busy2  : busy1;
    assign t_done  = sel_small ? done2  : done1;
    assign t_error = sel_small ? err2   : err1;
    assign t_addr  = sel_small ? {8'h00, addr2} : addr1;
    assign t_wdata = sel_small ? wdata2 : wdata1;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(rdy1), .req_op(req_op),
        .req_funct4(req_funct4), .req_pred(req_pred), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .imem_ready(imem_ready), .busy(busy1), .done(done1), .error(err1)
    );

    instr_encoder #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(rdy2), .req_op(req_op),
        .req_funct4(req_funct4), .req_pred(req_pred), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .imem_ready(imem_ready), .busy(busy2), .done(done2), .error(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) imem_ready = ($urandom_range(0, 3) != 0);
    end

    // Every completed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && t_we && imem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected write: addr=%0d data=0x%08h, required none", t_addr, t_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (t_addr !== mon_exp.addr || t_wdata !== mon_exp.word) begin
                    errors++;
                    $display("[TB] FAIL write: addr=%0d data=0x%08h, required addr=%0d data=0x%08h",
                             t_addr, t_wdata, mon_exp.addr, mon_exp.word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic req_t mk(input logic [2:0] op, input logic pred, input logic [3:0] f4,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [13:0] imm);
        req_t r;
        r.op = op; r.pred = pred; r.funct4 = f4;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Reference: each field weighted by its bit position, per instruction class.
    function automatic void refEncode(input req_t r, output logic [31:0] w, output bit legal);
        longint unsigned acc;
        longint unsigned imm;
        longint unsigned f4;
        imm   = 64'(r.imm);
        f4    = 64'(r.funct4);
        legal = 1'b1;
        acc   = 64'(r.op) * 64'h2000_0000 + 64'(r.pred) * 64'h1000_0000 + 64'(r.rs1) * 32;
        case (r.op)
            3'd0, 3'd5: acc += 64'(r.rs2) * 16384 + f4 * 1024 + 64'(r.rd);
            3'd1, 3'd2: acc += imm * 16384 + f4 * 1024 + 64'(r.rd);
            3'd3: begin
                if (f4 == 0 || f4 == 8)
                    acc += imm * 16384 + f4 * 1024 + 64'(r.rd);
                else if (f4 == 1 || f4 == 9)
                    acc += (imm / 32) * 524288 + 64'(r.rs2) * 16384 + f4 * 1024 + (imm % 32);
                else
                    legal = 1'b0;
            end
            3'd4: acc += imm * 16384 + (f4 % 8) * 1024 + 64'(r.rd);
            default: legal = 1'b0;
        endcase
        w = legal ? acc[31:0] : 32'h0;
    endfunction

    function automatic req_t randReq();
        req_t r;
        r.op     = 3'($urandom_range(0, 7));
        r.pred   = 1'($urandom_range(0, 1));
        r.funct4 = 4'($urandom);
        r.rd     = 5'($urandom);
        r.rs1    = 5'($urandom);
        r.rs2    = 5'($urandom);
        r.imm    = 14'($urandom);
        if (r.op == 3'd3 && $urandom_range(0, 3) != 0)
            r.funct4 = {$urandom_range(0, 1) == 1, 2'b00, $urandom_range(0, 1) == 1};
        return r;
    endfunction

    function automatic req_t randLegal();
        req_t        r;
        logic [31:0] w;
        bit          ok;
        r = randReq();
        refEncode(r, w, ok);
        for (int i = 0; i < 100 && !ok; i++) begin
            r = randReq();
            refEncode(r, w, ok);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveReq(input req_t r);
        req_op = r.op; req_pred = r.pred; req_funct4 = r.funct4;
        req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
        req_valid = 1'b1;
    endtask

    // Offers one request; the expectation is queued once the handshake is seen.
    task automatic applyStimulus(input req_t r, input logic [31:0] w, input bit legal);
        bit got = 1'b0;
        driveReq(r);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (t_ready) got = 1'b1;
        end
        if (got) begin
            if (legal) begin
                exp_q.push_back('{10'(next_addr), w});
                next_addr++;
            end else begin
                ill_seen = 1'b1;
            end
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake: req_ready=0 after 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic doStart();
        exp_q.delete();
        next_addr = 0;
        ill_seen  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy after start", {31'b0, t_busy}, 32'd1);
        checkOutput("done after start", {31'b0, t_done}, 32'd0);
        checkOutput("error after start", {31'b0, t_error}, 32'd0);
    endtask

    task automatic doFinish();
        exp_q.push_back('{10'(next_addr), EXIT_WORD});
        req_valid = 1'b0;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (t_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout: done=0 after 1000 cycles, required 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkEnd(input logic exp_err);
        checkOutput("done at end", {31'b0, t_done}, 32'd1);
        checkOutput("busy at end", {31'b0, t_busy}, 32'd0);
        checkOutput("error at end", {31'b0, t_error}, {31'b0, exp_err});
        checkOutput("pending writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " imem_we"}, {31'b0, we1}, 32'd0);
        checkOutput({tag, " imem_addr"}, {22'b0, addr1}, 32'd0);
        checkOutput({tag, " imem_wdata"}, wdata1, 32'd0);
        checkOutput({tag, " req_ready"}, {31'b0, rdy1}, 32'd0);
        checkOutput({tag, " busy"}, {31'b0, busy1}, 32'd0);
        checkOutput({tag, " done"}, {31'b0, done1}, 32'd0);
        checkOutput({tag, " error"}, {31'b0, err1}, 32'd0);
    endtask

    initial begin
        req_t        r;
        logic [31:0] w;
        bit          ok;

        tbl[0]  = '{mk(3'd0, 1'b0, 4'h1, 5'd3,  5'd1, 5'd2, 14'h0000), 32'h0000_8423, 1'b1};
        tbl[1]  = '{mk(3'd1, 1'b0, 4'h0, 5'd5,  5'd0, 5'd0, 14'h3FFF), 32'h2FFF_C005, 1'b1};
        tbl[2]  = '{mk(3'd0, 1'b0, 4'h0, 5'd0,  5'd0, 5'd0, 14'h0000), 32'h0000_0000, 1'b1};
        tbl[3]  = '{mk(3'd3, 1'b1, 4'h0, 5'd7,  5'd2, 5'd0, 14'h1234), 32'h748D_0047, 1'b1};
        tbl[4]  = '{mk(3'd3, 1'b0, 4'h1, 5'd31, 5'd4, 5'd9, 14'h2A5B), 32'h6A92_449B, 1'b1};
        tbl[5]  = '{mk(3'd4, 1'b1, 4'hA, 5'd0,  5'd3, 5'd0, 14'h0010), 32'h9004_0860, 1'b1};
        tbl[6]  = '{mk(3'd5, 1'b0, 4'h5, 5'd1,  5'd2, 5'd3, 14'h3FFF), 32'hA000_D441, 1'b1};
        tbl[7]  = '{mk(3'd2, 1'b1, 4'h3, 5'd2,  5'd1, 5'd7, 14'h0001), 32'h5000_4C22, 1'b1};
        tbl[8]  = '{mk(3'd3, 1'b0, 4'h9, 5'd0,  5'd0, 5'd1, 14'h0000), 32'h6000_6400, 1'b1};
        tbl[9]  = '{mk(3'd3, 1'b0, 4'h8, 5'd1,  5'd0, 5'd0, 14'h3FFF), 32'h6FFF_E001, 1'b1};
        tbl[10] = '{mk(3'd3, 1'b0, 4'h5, 5'd1,  5'd1, 5'd1, 14'h0001), 32'h0, 1'b0};
        tbl[11] = '{mk(3'd6, 1'b0, 4'h0, 5'd1,  5'd1, 5'd1, 14'h0001), 32'h0, 1'b0};
        tbl[12] = '{mk(3'd7, 1'b1, 4'hF, 5'd31, 5'd31, 5'd31, 14'h3FFF), 32'h0, 1'b0};

        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] latency and single R-type write");
        doStart();
        imem_ready = 1'b0;
        applyStimulus(tbl[0].req, tbl[0].word, 1'b1);
        @(negedge clk);
        checkOutput("latency imem_we", {31'b0, t_we}, 32'd1);
        checkOutput("latency imem_wdata", t_wdata, 32'h0000_8423);
        checkOutput("latency imem_addr", {22'b0, t_addr}, 32'd0);
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        doFinish();
        waitDone();
        checkEnd(1'b0);

        $display("[TB] encoding table");
        doStart();
        rand_rdy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].req, tbl[i].word, tbl[i].legal);
            checkOutput($sformatf("error after vector %0d", i), {31'b0, t_error}, {31'b0, ill_seen});
        end
        applyStimulus(tbl[7].req, tbl[7].word, 1'b1);
        doFinish();
        waitDone();
        checkEnd(1'b1);

        $display("[TB] back-pressure with full buffer");
        rand_rdy = 1'b0;
        doStart();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = randLegal();
            refEncode(r, w, ok);
            applyStimulus(r, w, ok);
        end
        r = randLegal();
        driveReq(r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("req_ready while full", {31'b0, t_ready}, 32'd0);
            checkOutput("held imem_wdata", t_wdata, exp_q[0].word);
            checkOutput("held imem_addr", {22'b0, t_addr}, 32'd0);
        end
        @(posedge clk);
        #1;
        imem_ready = 1'b1;
        refEncode(r, w, ok);
        applyStimulus(r, w, ok);
        doFinish();
        waitDone();
        checkEnd(1'b0);

        $display("[TB] randomized traffic");
        doStart();
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = randReq();
            refEncode(r, w, ok);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(r, w, ok);
        end
        doFinish();
        waitDone();
        checkEnd(ill_seen);

        $display("[TB] address overflow on 2-bit address instance");
        rand_rdy = 1'b0;
        imem_ready = 1'b1;
        sel_small = 1'b1;
        doStart();
        for (int i = 0; i < 5; i++) begin
            r = randLegal();
            refEncode(r, w, ok);
            applyStimulus(r, w, ok);
        end
        mon_exp = exp_q.pop_back();
        waitDone();
        checkOutput("overflow error", {31'b0, t_error}, 32'd1);
        checkOutput("overflow done", {31'b0, t_done}, 32'd1);
        checkOutput("overflow busy", {31'b0, t_busy}, 32'd0);
        checkOutput("overflow imem_we", {31'b0, t_we}, 32'd0);
        checkOutput("overflow pending", 32'(exp_q.size()), 32'd0);
        sel_small = 1'b0;

        $display("[TB] reset in the middle of a program");
        doStart();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r = randLegal();
            refEncode(r, w, ok);
            applyStimulus(r, w, ok);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid reset");
        checkOutput("mid reset small imem_we", {31'b0, we2}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        checkOutput("post reset imem_we", {31'b0, t_we}, 32'd0);
        checkOutput("post reset busy", {31'b0, t_busy}, 32'd0);
        @(posedge clk);
        #1;
        doStart();
        r = randLegal();
        refEncode(r, w, ok);
        applyStimulus(r, w, ok);
        doFinish();
        waitDone();
        checkEnd(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, 10, instruction-memory word-address width.
REQ-003 Parameter FIFO_DEPTH, 4, encoded-word buffer depth (power of two).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  pulse: clear address counter and error state, enter RUN.
REQ-007 finish  input  1  pulse: stop accepting requests, drain buffer, append EXIT.
REQ-008 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-009 req_op  input  3  instruction class, using the shared `Rtype..`Ftype codes.
REQ-010 req_funct4  input  4  funct4; for `Ctype only bits [2:0] (funct3) are used.
REQ-011 req_pred, req_rd, req_rs1, req_rs2  input  1/5/5/5  predicate and register fields.
REQ-012 req_imm  input  14  signed immediate.
REQ-013 imem_we  output  1  write strobe to instruction memory.
REQ-014 imem_addr, imem_wdata  output  ADDR_WIDTH / DATA_WIDTH  write address and word.
REQ-015 imem_ready  input  1  memory accepts the write this cycle.
REQ-016 busy, done, error  output  1 each  status; done and error are sticky until start.

Function
REQ-017 Word layout: [31:29] op, [28] pred, [13:10] funct4, [9:5] rs1, [4:0] rd; unused bits zero.
REQ-018 `Rtype, `Ftype: [18:14] = rs2; [27:19] zero.
REQ-019 `Itype, `Ptype, `Mtype load (funct4 0000/1000): [27:14] = imm.
REQ-020 `Mtype store (funct4 0001/1001): [27:14] = imm, [18:14] overwritten by rs2 is illegal; imm[4:0] carried in [4:0] instead of rd, rs2 in [18:14], imm[13:5] in [27:19].
REQ-021 `Ctype: [12:10] = funct3, bit 13 zero; jump/call/branch: [27:14] = imm.
REQ-022 Illegal request: op outside the six classes, or `Mtype funct4 not in {0000,0001,1000,1001}; the request is accepted, dropped, and error is set.
REQ-023 An all-zero R-type request (rd=rs1=rs2=0, funct4=0) encodes to 32'h0 (NOP).
REQ-024 FSM states IDLE, RUN, DRAIN, EXIT, DONE; reset state IDLE.
REQ-025 IDLE->RUN on start; RUN->DRAIN on finish; DRAIN->EXIT when FIFO empty and no write pending; EXIT->DONE when the EXIT word is accepted; DONE->RUN on start.
REQ-026 req_ready = (state==RUN) && FIFO not full && !finish; encode and push in the accept cycle.
REQ-027 FIFO head drives imem_wdata; imem_we = FIFO non-empty in RUN/DRAIN, or state==EXIT.
REQ-028 A write completes when imem_we && imem_ready; then pop and increment address; outputs hold stable while imem_ready=0.
REQ-029 EXIT word: op=`Ctype, funct3=111, all other bits zero, written at the current address.
REQ-030 Latency: accepted request appears on imem_wdata the next cycle when the FIFO was empty.
REQ-031 Simultaneous push and pop with FIFO full is not possible (ready low); with FIFO non-full both occur.
REQ-032 Address overflow: a completed write at address 2^ADDR_WIDTH-1 (other than EXIT) sets error and forces EXIT state; no wrap-around writes.
REQ-033 start while busy restarts: FIFO flushed, address 0, error and done cleared.
REQ-034 busy = state in {RUN, DRAIN, EXIT}.

Reset
REQ-035 On rst_n low: state IDLE, FIFO empty, address 0, imem_we 0, imem_addr 0, imem_wdata 0, req_ready 0, busy 0, done 0, error 0.
REQ-036 Reset mid-write abandons the write; no partial state survives.

Structure
REQ-037 Class codes, funct4 encodings, and EXIT/NOP word constants live in the shared define package with the decoder's codes.
REQ-038 One sub-module: instr_fifo (synchronous, FIFO_DEPTH entries, full/empty flags); encoding is combinational in instr_encoder.

Verification
REQ-039 start; R-type funct4=`ALU_SUB rd=3 rs1=1 rs2=2 -> one write at addr 0 with [18:14]=2, [9:5]=1, [4:0]=3, op=`Rtype.
REQ-040 I-type ADD imm=-1 rd=5 -> [27:14]=14'h3FFF, [4:0]=5; decoder round-trip yields ALUsrc=1, RegWrite=1.
REQ-041 Three requests, then finish -> writes at addr 0,1,2, EXIT at addr 3, done=1, busy=0.
REQ-042 imem_ready held 0 for 5 cycles with 4 requests -> req_ready drops after FIFO full, imem_wdata stable, no loss.
REQ-043 `Mtype funct4=0101 -> no write, error=1; subsequent legal request still written.
REQ-044 ADDR_WIDTH=2, 5 requests -> writes at 0..3, error=1, no EXIT write, done=1; rst_n low mid-stream -> all outputs 0 within the cycle.
